// File: rtl/shiftreg_pkg.sv
// Shared types and constants for the framed shift register and its bit counter.
package shiftreg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_bit_counter.sv
// Counts shifts within a frame; terminal flags the increment that completes WIDTH bits.
module shift_bit_counter #(
  parameter int  WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  assign terminal = inc && (count == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || terminal) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/framed_shiftregister.sv
// Full-duplex SIPO/PISO shift register with selectable direction and frame tracking.
module framed_shiftregister
  import shiftreg_pkg::*;
#(
  parameter int  WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             peripheralClkEdge,
  input  logic             parallelLoad,
  input  logic [WIDTH-1:0] parallelDataIn,
  input  logic             serialDataIn,
  input  logic             lsbFirst,
  output logic [WIDTH-1:0] parallelDataOut,
  output logic             serialDataOut,
  output logic [WIDTH-1:0] rxData,
  output logic             frameDone,
  output logic             busy,
  output logic [CNT_W-1:0] bitCount
);

  state_t           state;
  state_t           nextState;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] shiftedData;
  logic             dir;
  logic             shiftStrobe;
  logic             counterInc;
  logic             terminal;

  // A load in the same cycle swallows the strobe.
  assign shiftStrobe = peripheralClkEdge && !parallelLoad;
  assign counterInc  = shiftStrobe && (state == SHIFT);

  shift_bit_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (parallelLoad),
    .inc      (counterInc),
    .count    (bitCount),
    .terminal (terminal)
  );

  always_comb begin
    shiftedData = {data[WIDTH-2:0], serialDataIn};
    if (dir == DIR_LSB_FIRST) begin
      shiftedData = {serialDataIn, data[WIDTH-1:1]};
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    nextState = state;
    if (parallelLoad) begin
      nextState = SHIFT;
    end else if (terminal) begin
      nextState = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= nextState;
      busy  <= (nextState == SHIFT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data            <= '0;
      dir             <= DIR_MSB_FIRST;
      parallelDataOut <= '0;
      serialDataOut   <= 1'b0;
      rxData          <= '0;
      frameDone       <= 1'b0;
    end else begin
      parallelDataOut <= data;
      serialDataOut   <= (dir == DIR_LSB_FIRST) ? data[0] : data[WIDTH-1];
      frameDone       <= terminal;
      if (parallelLoad) begin
        data <= parallelDataIn;
        dir  <= lsbFirst;
      end else if (shiftStrobe) begin
        data <= shiftedData;
      end
      // The completing strobe's own bit is part of the received word.
      if (terminal) begin
        rxData <= shiftedData;
      end
    end
  end

endmodule

// File: tb/tb_framed_shiftregister.sv
// Randomised scoreboard bench for framed_shiftregister (WIDTH=8).
module tb_framed_shiftregister;

  localparam int W     = 8;
  localparam int CNT_W = $clog2(W + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             peripheralClkEdge;
  logic             parallelLoad;
  logic [W-1:0]     parallelDataIn;
  logic             serialDataIn;
  logic             lsbFirst;
  logic [W-1:0]     parallelDataOut;
  logic             serialDataOut;
  logic [W-1:0]     rxData;
  logic             frameDone;
  logic             busy;
  logic [CNT_W-1:0] bitCount;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] expRxQ[$];
  logic [W-1:0] lastRx;

  framed_shiftregister #(.WIDTH(W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .peripheralClkEdge (peripheralClkEdge),
    .parallelLoad      (parallelLoad),
    .parallelDataIn    (parallelDataIn),
    .serialDataIn      (serialDataIn),
    .lsbFirst          (lsbFirst),
    .parallelDataOut   (parallelDataOut),
    .serialDataOut     (serialDataOut),
    .rxData            (rxData),
    .frameDone         (frameDone),
    .busy              (busy),
    .bitCount          (bitCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic strobe(input logic b);
    peripheralClkEdge = 1'b1;
    serialDataIn      = b;
    cycle();
    peripheralClkEdge = 1'b0;
    serialDataIn      = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] word, input logic lsb);
    parallelLoad   = 1'b1;
    parallelDataIn = word;
    lsbFirst       = lsb;
    cycle();
    parallelLoad   = 1'b0;
    check("load_bitCount", 32'(bitCount), 0);
    check("load_busy", 32'(busy), 1);
  endtask

  // Expected words follow from the framing rules: the k-th transmitted bit is
  // word bit (W-1-k) MSB-first or bit k LSB-first; received bits fill the word
  // from the top down when MSB-first and from bit 0 upwards when LSB-first.
  task automatic runFrame(input logic [W-1:0] word, input logic lsb,
                          input logic [W-1:0] bits, input int gap);
    logic [W-1:0] rx;
    logic         txBit;
    rx = '0;
    for (int k = 0; k < W; k++) begin
      if (lsb) rx[k] = bits[k];
      else     rx    = {rx[W-2:0], bits[k]};
    end
    expRxQ.push_back(rx);
    load(word, lsb);
    for (int k = 0; k < W; k++) begin
      strobe(bits[k]);
      txBit = lsb ? word[k] : word[W-1-k];
      check($sformatf("tx_bit%0d", k), 32'(serialDataOut), 32'(txBit));
      check("frame_bitCount", 32'(bitCount), (k == W - 1) ? 0 : k + 1);
      check("frame_busy", 32'(busy), (k == W - 1) ? 0 : 1);
      if (k != W - 1) idle(gap);
    end
    check("end_frameDone", 32'(frameDone), 1);
    check("end_rxData", 32'(rxData), 32'(rx));
    cycle();
    check("after_frameDone", 32'(frameDone), 0);
    check("after_pdo", 32'(parallelDataOut), 32'(rx));
    lastRx = rx;
  endtask

  // Monitor: every frameDone pulse must match the oldest expected frame.
  initial begin : monitor
    logic [W-1:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (frameDone === 1'b1) begin
        if (expRxQ.size() == 0) begin
          check("unexpected_frameDone", 32'(frameDone), 0);
        end else begin
          exp = expRxQ.pop_front();
          check("sb_rxData", 32'(rxData), 32'(exp));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [W-1:0] w;
    logic [W-1:0] b;
    logic         l;

    rst_n = 1'b0; peripheralClkEdge = 1'b1; parallelLoad = 1'b1;
    parallelDataIn = 8'hFF; serialDataIn = 1'b1; lsbFirst = 1'b1;
    idle(2);
    check("rst_pdo", 32'(parallelDataOut), 0);
    check("rst_sdo", 32'(serialDataOut), 0);
    check("rst_rx", 32'(rxData), 0);
    check("rst_frameDone", 32'(frameDone), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_bitCount", 32'(bitCount), 0);
    peripheralClkEdge = 1'b0; parallelLoad = 1'b0; serialDataIn = 1'b0; lsbFirst = 1'b0;
    rst_n = 1'b1;
    cycle();
    check("post_rst_busy", 32'(busy), 0);
    lastRx = '0;

    // Directed frames; bits listed in transmission order (bit 0 first).
    runFrame(8'hA5, 1'b0, 8'b0100_1101, 3);
    check("msb_rx", 32'(lastRx), 32'hB2);
    runFrame(8'h01, 1'b1, 8'hFF, 1);
    check("lsb_rx", 32'(lastRx), 32'hFF);

    // Reload mid-frame: the abandoned frame must not complete.
    load(8'hC3, 1'b0);
    strobe(1'b1); strobe(1'b0); strobe(1'b1);
    check("mid_bitCount", 32'(bitCount), 3);
    runFrame(8'h3C, 1'b0, 8'b1010_0110, 0);

    // Load and strobe together: strobe dropped.
    parallelLoad = 1'b1; parallelDataIn = 8'h5A; lsbFirst = 1'b0;
    peripheralClkEdge = 1'b1; serialDataIn = 1'b1;
    cycle();
    parallelLoad = 1'b0; peripheralClkEdge = 1'b0;
    check("simul_bitCount", 32'(bitCount), 0);
    cycle();
    check("simul_pdo", 32'(parallelDataOut), 32'h5A);

    // Reset in the middle of a frame.
    for (int i = 0; i < 5; i++) strobe(1'(i));
    check("pre_rst_bitCount", 32'(bitCount), 5);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("mrst_pdo", 32'(parallelDataOut), 0);
    check("mrst_rx", 32'(rxData), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_bitCount", 32'(bitCount), 0);
    check("mrst_frameDone", 32'(frameDone), 0);

    // Free-running shifting outside a frame.
    for (int i = 0; i < W; i++) begin
      strobe(1'b1);
      check("idle_bitCount", 32'(bitCount), 0);
      check("idle_busy", 32'(busy), 0);
    end
    cycle();
    check("idle_pdo", 32'(parallelDataOut), 32'hFF);

    // Randomised frames.
    for (int f = 0; f < 20; f++) begin
      w = W'($urandom);
      b = W'($urandom);
      l = 1'($urandom_range(0, 1));
      runFrame(w, l, b, int'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    check("pending_frames", 32'(expRxQ.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/framed_shiftregister.md
Name: framed_shiftregister

Overview:
Parametrised full-duplex shift register with frame control, the next generation of the team's SIPO/PISO shift register.
- Adds a selectable shift direction, a bit counter, a frame-complete pulse and a latched receive word.
- Sits between the peripheral edge detector, which supplies the shift strobe, and the SPI-style protocol FSM.
- Outside a frame it still behaves as a plain free-running shift register.

Parameters:
- WIDTH, 8, shift register length in bits; must be >= 2.
- CNT_W, $clog2(WIDTH+1), derived local parameter; width of the bit counter. Not overridable.

Ports:
- clk  input  1  FPGA clock; all logic is on its rising edge.
- rst_n  input  1  Synchronous, active-low reset.
- peripheralClkEdge  input  1  Shift strobe, one clk cycle wide.
- parallelLoad  input  1  Loads parallelDataIn and starts a frame.
- parallelDataIn  input  WIDTH  Transmit word.
- serialDataIn  input  1  Receive bit, sampled on a strobe.
- lsbFirst  input  1  Shift direction; sampled only on parallelLoad.
- parallelDataOut  output  WIDTH  Registered copy of the live shift contents.
- serialDataOut  output  1  Registered current transmit bit.
- rxData  output  WIDTH  Received word, latched at frame end.
- frameDone  output  1  One-cycle pulse when a frame completes.
- busy  output  1  High while in the SHIFT state.
- bitCount  output  CNT_W  Number of shifts completed in the current frame.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - data, dir, parallelDataOut, serialDataOut, rxData, frameDone, busy and bitCount all go to 0.
  - dir=0 means MSB-first. State goes to IDLE.
  - Reset overrides every other input and aborts any frame in progress.
- States are IDLE and SHIFT.
- Priority per cycle: reset > parallelLoad > peripheralClkEdge.
- parallelLoad (either state):
  - data <= parallelDataIn; dir <= lsbFirst; bitCount <= 0; state <= SHIFT.
  - A strobe in the same cycle is dropped.
  - A load during SHIFT abandons the current frame: no frameDone, rxData unchanged.
- Shift on peripheralClkEdge without load:
  - MSB-first: data <= {data[WIDTH-2:0], serialDataIn}.
  - LSB-first: data <= {serialDataIn, data[WIDTH-1:1]}.
  - Exactly WIDTH bits are kept; the bit shifted out is discarded.
- IDLE shifting: a strobe shifts data in the current dir. bitCount stays 0, no frameDone, busy=0.
- SHIFT counting: each strobe increments bitCount. The strobe that brings bitCount to WIDTH does all of the following at the same edge:
  - rxData <= shifted data (including that final serialDataIn bit);
  - frameDone <= 1 for exactly one cycle;
  - state <= IDLE, busy <= 0, bitCount <= 0.
- busy and bitCount are registered and reflect the state after each edge.
- serialDataOut <= data[WIDTH-1] (dir=0) or data[0] (dir=1), every cycle.
  - It lags data by one clk, so the first transmit bit appears 2 clk after parallelLoad.
- parallelDataOut <= data every cycle (one clk lag).
- Strobes one clk apart are legal; each strobe causes exactly one shift.

Decomposition:
- Package shiftreg_pkg holds:
  - state typedef {IDLE, SHIFT};
  - constants DIR_MSB_FIRST=1'b0 and DIR_LSB_FIRST=1'b1.
- One natural sub-module, shift_bit_counter:
  - parametrised on WIDTH;
  - inputs clear and inc;
  - outputs count and terminal, where terminal is high when count==WIDTH-1 and inc is high.
- The shift datapath, FSM and output registers stay in the top module.

Test Plan (WIDTH=8):
1. Reset: hold rst_n=0 for 2 cycles with parallelLoad=1 and peripheralClkEdge=1 -> all outputs 0, busy=0. First cycle after release is IDLE.
2. MSB-first full duplex: load 0xA5 with lsbFirst=0, then 8 strobes 4 clk apart with serialDataIn = 1,0,1,1,0,0,1,0.
   - serialDataOut sequence is 1,0,1,0,0,1,0,1.
   - After the 8th strobe edge: frameDone=1 for one cycle, rxData=0xB2, busy=0, bitCount=0.
3. LSB-first: load 0x01 with lsbFirst=1, serialDataIn=1 for all strobes.
   - serialDataOut sequence is 1,0,0,0,0,0,0,0.
   - rxData=0xFF and frameDone pulses once.
4. Reload mid-frame: after 3 strobes, load 0x3C.
   - bitCount=0 and no frameDone pulse.
   - frameDone pulses only after 8 further strobes; serialDataOut starts 0,0,1,1.
5. Simultaneous events:
   - parallelLoad and strobe together with 0x5A -> parallelDataOut=0x5A (unshifted), bitCount=0.
   - rst_n=0 at bitCount=5 -> all outputs 0, rxData keeps 0, no frameDone.
6. IDLE shifting: 8 strobes with serialDataIn=1 and no load.
   - parallelDataOut reaches 0xFF.
   - frameDone never asserts; bitCount stays 0; busy stays 0.
